// File: rtl/jump_encoder.sv
// J-type jump encoder with a one-entry output register and saturating result counters.
// Optional target checking is enabled by defining JUMP_ENCODER_RANGE_CHECK_EN.
module jump_encoder #(
  parameter logic [5:0] OP_J   = 6'b000010,
  parameter logic [5:0] OP_JAL = 6'b000011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_next,
  input  logic [31:0] target,
  input  logic        link,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [1:0]  err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] enc_q, enc_d;
  logic        accept, consume, held_ok;
  logic [5:0]  opcode;
  logic [31:0] instr_calc;

  assign opcode   = link ? OP_JAL : OP_J;
  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // flush discards the held result, so it never counts as a consume
  assign consume  = valid_q && out_ready && !flush;

`ifdef JUMP_ENCODER_RANGE_CHECK_EN
  logic [1:0] err_calc, err_q, err_d;
  logic [7:0] errc_q, errc_d;
  logic       unused_pc;

  assign err_calc   = {target[31:28] != pc_next[31:28], target[1:0] != 2'b00};
  assign instr_calc = (err_calc != 2'b00) ? 32'h0 : {opcode, target[27:2]};
  assign held_ok    = (err_q == 2'b00);
  assign unused_pc  = ^pc_next[27:0];

  always_comb begin
    err_d  = err_q;
    errc_d = errc_q;
    if (consume && !held_ok && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
    if (!flush && accept) err_d = err_calc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 2'b00;
      errc_q <= 8'h00;
    end else begin
      err_q  <= err_d;
      errc_q <= errc_d;
    end
  end

  assign err       = err_q;
  assign err_count = errc_q;
`else
  logic unused_fields;

  assign instr_calc    = {opcode, target[27:2]};
  assign held_ok       = 1'b1;
  assign unused_fields = ^{pc_next, target[31:28], target[1:0]};
  assign err           = 2'b00;
  assign err_count     = 8'h00;
`endif

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    enc_d   = enc_q;
    if (consume && held_ok && enc_q != 16'hFFFF) enc_d = enc_q + 16'd1;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = instr_calc;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      enc_q   <= 16'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      enc_q   <= enc_d;
    end
  end

  assign out_valid = valid_q;
  assign instr     = instr_q;
  assign enc_count = enc_q;

endmodule

// File: tb/tb_jump_encoder.sv
// Scoreboard bench for jump_encoder: driver pushes expected results, a negedge monitor checks.
module tb_jump_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_next;
  logic [31:0] target;
  logic        link;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [1:0]  err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  jump_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_next   (pc_next),
    .target    (target),
    .link      (link),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_enc = 16'h0;
  logic [7:0]  exp_errc = 8'h0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_instr;
  logic [1:0]  prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: model of valid/ready/counters plus scoreboard pop on each consume.
  always @(negedge clk) begin
    exp_t e;
    logic consume, accept;
    if (!rst_n) begin
      q.delete();
      exp_valid = 1'b0;
      exp_enc   = 16'h0;
      exp_errc  = 8'h0;
      hold_prev = 1'b0;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_enc_count", {16'h0, enc_count}, 32'h0);
    end else begin
      chk("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      chk("in_ready", {31'h0, in_ready}, {31'h0, !flush && (!exp_valid || out_ready)});
      chk("enc_count", {16'h0, enc_count}, {16'h0, exp_enc});
      chk("err_count", {24'h0, err_count}, {24'h0, exp_errc});
      if (hold_prev && out_valid) begin
        chk("stable_instr", instr, prev_instr);
        chk("stable_err", {30'h0, err}, {30'h0, prev_err});
      end
      consume = out_valid && out_ready && !flush;
      accept  = in_valid && !flush && (!exp_valid || out_ready);
      if (flush && out_valid) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (consume) begin
        if (q.size() == 0) begin
          chk("unexpected_result", instr, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          chk("instr", instr, e.instr);
          chk("err", {30'h0, err}, {30'h0, e.err});
          if (e.err == 2'b00) begin
            if (exp_enc != 16'hFFFF) exp_enc = exp_enc + 16'd1;
          end else begin
            if (exp_errc != 8'hFF) exp_errc = exp_errc + 8'd1;
          end
        end
      end
      exp_valid  = flush ? 1'b0 : accept ? 1'b1 : consume ? 1'b0 : exp_valid;
      hold_prev  = out_valid && !out_ready && !flush;
      prev_instr = instr;
      prev_err   = err;
    end
  end

  // Drive a request and wait (bounded) for acceptance; push its expected result on accept.
  task automatic issue(input logic [31:0] pc, input logic [31:0] tgt, input logic lnk,
                       input logic [31:0] ei, input logic [1:0] ee);
    exp_t e;
    pc_next  = pc;
    target   = tgt;
    link     = lnk;
    in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n == 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no_accept expected=accept at %0t", $time);
        in_valid = 1'b0;
        return;
      end
    end
    e.instr = ei;
    e.err   = ee;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    pc_next   = 32'h0;
    target    = 32'h0;
    link      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_instr", instr, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Directed vectors, back-to-back
    issue(32'h0040_0004, 32'h0040_0020, 1'b0, 32'h0810_0008, 2'b00);
    issue(32'h0040_0004, 32'h0040_0020, 1'b1, 32'h0C10_0008, 2'b00);
    issue(32'h0000_0000, 32'h0FFF_FFFC, 1'b1, 32'h0FFF_FFFF, 2'b00);
`ifdef JUMP_ENCODER_RANGE_CHECK_EN
    issue(32'h0040_0004, 32'h0040_0022, 1'b0, 32'h0000_0000, 2'b01);
    issue(32'h0040_0004, 32'hF000_0000, 1'b0, 32'h0000_0000, 2'b10);
    issue(32'h0000_0000, 32'h1000_0003, 1'b1, 32'h0000_0000, 2'b11);
`else
    issue(32'h0040_0004, 32'h0040_0022, 1'b0, 32'h0810_0008, 2'b00);
    issue(32'h0040_0004, 32'hF000_0000, 1'b0, 32'h0800_0000, 2'b00);
    issue(32'h0000_0000, 32'h1000_0003, 1'b1, 32'h0C00_0000, 2'b00);
`endif
    idle(2);

    // Backpressure: hold A, present B for 5 cycles, then release
    out_ready = 1'b0;
    issue(32'h1234_0004, 32'h1234_5678, 1'b0, 32'h088D_159E, 2'b00);
    pc_next  = 32'h2000_0004;
    target   = 32'h2000_0100;
    link     = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'h2000_0004, 32'h2000_0100, 1'b1, 32'h0C00_0040, 2'b00);
    issue(32'h2000_0004, 32'h2000_0200, 1'b0, 32'h0800_0080, 2'b00);
    issue(32'h2000_0004, 32'h2000_0300, 1'b1, 32'h0C00_00C0, 2'b00);
    idle(2);

    // Flush while holding a result with a new request pending
    out_ready = 1'b0;
    issue(32'h0040_0004, 32'h0040_0040, 1'b0, 32'h0810_0010, 2'b00);
    target   = 32'h0040_0080;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    issue(32'h0040_0004, 32'h0040_0044, 1'b1, 32'h0C10_0011, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_err", {30'h0, err}, 32'h0);
    chk("arst_enc_count", {16'h0, enc_count}, 32'h0);
    chk("arst_err_count", {24'h0, err_count}, 32'h0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
    idle(1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    issue(32'h0040_0004, 32'h0040_0020, 1'b0, 32'h0810_0008, 2'b00);
    idle(2);

`ifdef JUMP_ENCODER_RANGE_CHECK_EN
    for (int i = 0; i < 260; i++)
      issue(32'h0040_0004, 32'h0040_0021, 1'b0, 32'h0000_0000, 2'b01);
    idle(2);
    chk("err_count_sat", {24'h0, err_count}, 32'h0000_00FF);
`endif

    for (int i = 0; i < 65540; i++)
      issue(32'h0040_0004, 32'h0040_0020, 1'b1, 32'h0C10_0008, 2'b00);
    idle(3);
    chk("enc_count_sat", {16'h0, enc_count}, 32'h0000_FFFF);
    chk("scoreboard_empty", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
